// File: rtl/noc_router_mesh.sv
// noc_router_mesh: 5-port (L,N,E,W,S) wormhole mesh router with XY routing and packet-locked round-robin outputs.
// Optional feature macro: NOC_PARITY_EN (even parity in bit 0, checked on input write, regenerated on output).
module noc_router_mesh #(
   parameter int         DATA_WIDTH = 32,
   parameter int         FIFO_DEPTH = 4,
   parameter int         COORD_W    = 2,
   parameter int         CUR_X      = 0,
   parameter int         CUR_Y      = 0,
   parameter logic [4:0] CONN       = 5'b11111
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [5*DATA_WIDTH-1:0] rx,
   input  logic [4:0]              drts,
   output logic [4:0]              cts,
   output logic [5*DATA_WIDTH-1:0] tx,
   output logic [4:0]              rts,
   input  logic [4:0]              dcts,
   output logic [4:0]              route_err,
   output logic [4:0]              parity_err
);
   localparam int DW     = DATA_WIDTH;
   localparam int ADDR_W = 2 * COORD_W;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [2:0]         T_HEAD   = 3'b001;
   localparam logic [2:0]         T_TAIL   = 3'b100;
   localparam logic [COORD_W-1:0] MY_X     = COORD_W'(CUR_X);
   localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(CUR_Y);
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_FWD = 2'd2, S_DROP = 2'd3} in_state_t;

   function automatic logic par_even(input logic [DW-1:0] f);
      return ^f[DW-1:1];
   endfunction

   function automatic logic [DW-1:0] out_flit(input logic [DW-1:0] f);
`ifdef NOC_PARITY_EN
      return {f[DW-1:1], par_even(f)};
`else
      return f;
`endif
   endfunction

   function automatic logic [2:0] xy_route(input logic [ADDR_W-1:0] dst);
      logic [COORD_W-1:0] dx;
      logic [COORD_W-1:0] dy;
      dx = dst[COORD_W-1:0];
      dy = dst[ADDR_W-1:COORD_W];
      if (dx > MY_X)      return 3'd2;
      else if (dx < MY_X) return 3'd3;
      else if (dy > MY_Y) return 3'd4;
      else if (dy < MY_Y) return 3'd1;
      else                return 3'd0;
   endfunction

   function automatic logic [2:0] rr_idx(input logic [2:0] last, input int k);
      return 3'((int'(last) + 1 + k) % 5);
   endfunction

   logic [DW-1:0]    mem_r [5][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r [5];
   logic [PTR_W-1:0] rd_ptr_r [5];
   logic [CNT_W-1:0] cnt_r [5];
   logic [CNT_W-1:0] cnt_next_s [5];
   logic [DW-1:0]    head_s [5];
   logic [2:0]       route_s [5];
   logic [2:0]       route_r [5];
   in_state_t        state_r [5];
   in_state_t        state_s [5];
   logic [2:0]       owner_r [5];
   logic [2:0]       last_r [5];
   logic [2:0]       gnt_idx_s [5];
   logic [DW-1:0]    tx_r [5];
   logic [4:0] empty_s, wr_s, pop_s, par_bad_s, fwd_s, gnt_vld_s, granted_s, drop_err_s;
   logic [4:0] cts_r, rts_r, route_err_r, parity_err_r, lock_r;

   // FIFO head view, write qualification, next occupancy and parity check per input
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         head_s[i]  = mem_r[i][rd_ptr_r[i]];
         empty_s[i] = (cnt_r[i] == {CNT_W{1'b0}});
         wr_s[i]    = drts[i] & cts_r[i];
         route_s[i] = xy_route(head_s[i][DW-16 -: ADDR_W]);
`ifdef NOC_PARITY_EN
         par_bad_s[i] = wr_s[i] & (^rx[i*DW +: DW]);
`else
         par_bad_s[i] = 1'b0;
`endif
         case ({wr_s[i], pop_s[i]})
            2'b10:   cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
            2'b01:   cnt_next_s[i] = cnt_r[i] - CNT_W'(1);
            default: cnt_next_s[i] = cnt_r[i];
         endcase
      end
   end

   // Output arbitration: round-robin grant on free outputs, forwarding on locked ones
   always_comb begin
      granted_s = 5'b00000;
      for (int o = 0; o < 5; o++) begin
         gnt_vld_s[o] = 1'b0;
         gnt_idx_s[o] = 3'd0;
         if (!lock_r[o] && CONN[o]) begin
            for (int k = 0; k < 5; k++) begin
               if (!gnt_vld_s[o] && state_r[rr_idx(last_r[o], k)] == S_REQ &&
                   route_r[rr_idx(last_r[o], k)] == 3'(o)) begin
                  gnt_vld_s[o] = 1'b1;
                  gnt_idx_s[o] = rr_idx(last_r[o], k);
               end else begin
                  gnt_vld_s[o] = gnt_vld_s[o];
               end
            end
         end else begin
            gnt_vld_s[o] = 1'b0;
         end
         fwd_s[o] = lock_r[o] & ~empty_s[owner_r[o]] & dcts[o];
         if (gnt_vld_s[o]) granted_s[gnt_idx_s[o]] = 1'b1;
         else              granted_s = granted_s;
      end
   end

   // Per-input pop decision and packet FSM next state
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         pop_s[i]      = 1'b0;
         state_s[i]    = state_r[i];
         drop_err_s[i] = 1'b0;
         case (state_r[i])
            S_IDLE: begin
               // Stray body/tail flits at the head are discarded to resynchronise
               pop_s[i] = ~empty_s[i] & (head_s[i][DW-1 -: 3] != T_HEAD);
               if (!empty_s[i] && head_s[i][DW-1 -: 3] == T_HEAD) state_s[i] = S_REQ;
               else                                                state_s[i] = S_IDLE;
            end
            S_REQ: begin
               if (!CONN[route_r[i]]) begin
                  state_s[i]    = S_DROP;
                  drop_err_s[i] = 1'b1;
               end else if (granted_s[i]) begin
                  state_s[i] = S_FWD;
               end else begin
                  state_s[i] = S_REQ;
               end
            end
            S_FWD, S_DROP: begin
               pop_s[i] = (state_r[i] == S_FWD) ? fwd_s[route_r[i]] : ~empty_s[i];
               if (pop_s[i] && head_s[i][DW-1 -: 3] == T_TAIL) state_s[i] = S_IDLE;
               else                                            state_s[i] = state_r[i];
            end
            default: state_s[i] = S_IDLE;
         endcase
      end
   end

   // Input FIFO storage, pointers, registered cts and sticky parity flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < FIFO_DEPTH; d++) mem_r[i][d] <= {DW{1'b0}};
            wr_ptr_r[i] <= {PTR_W{1'b0}};
            rd_ptr_r[i] <= {PTR_W{1'b0}};
            cnt_r[i]    <= {CNT_W{1'b0}};
         end
         cts_r        <= 5'b00000;
         parity_err_r <= 5'b00000;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (wr_s[i]) begin
               mem_r[i][wr_ptr_r[i]] <= rx[i*DW +: DW];
               wr_ptr_r[i]           <= wr_ptr_r[i] + PTR_W'(1);
            end
            if (pop_s[i]) rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
            cnt_r[i] <= cnt_next_s[i];
            cts_r[i] <= (cnt_next_s[i] != FULL_CNT);
            if (par_bad_s[i]) parity_err_r[i] <= 1'b1;
         end
      end
   end

   // Input FSM state, captured route and route error pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            state_r[i] <= S_IDLE;
            route_r[i] <= 3'd0;
         end
         route_err_r <= 5'b00000;
      end else begin
         for (int i = 0; i < 5; i++) begin
            state_r[i] <= state_s[i];
            if (state_r[i] == S_IDLE) route_r[i] <= route_s[i];
         end
         route_err_r <= drop_err_s;
      end
   end

   // Output locks, round-robin history and registered flit outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int o = 0; o < 5; o++) begin
            owner_r[o] <= 3'd0;
            last_r[o]  <= 3'd0;
            tx_r[o]    <= {DW{1'b0}};
         end
         lock_r <= 5'b00000;
         rts_r  <= 5'b00000;
      end else begin
         for (int o = 0; o < 5; o++) begin
            if (gnt_vld_s[o]) begin
               lock_r[o]  <= 1'b1;
               owner_r[o] <= gnt_idx_s[o];
               last_r[o]  <= gnt_idx_s[o];
            end else if (fwd_s[o] && head_s[owner_r[o]][DW-1 -: 3] == T_TAIL) begin
               lock_r[o] <= 1'b0;
            end
            rts_r[o] <= fwd_s[o];
            if (fwd_s[o]) tx_r[o] <= out_flit(head_s[owner_r[o]]);
         end
      end
   end

   // Flatten per-port output registers onto the bus
   always_comb begin
      for (int o = 0; o < 5; o++) tx[o*DW +: DW] = tx_r[o];
   end

   assign cts        = cts_r;
   assign rts        = rts_r;
   assign route_err  = route_err_r;
   assign parity_err = parity_err_r;
endmodule

// File: tb/tb_noc_router_mesh.sv
// Directed bench for noc_router_mesh: two instances at (1,1), one fully connected, one without South.
`timescale 1ns/1ps
module tb_noc_router_mesh;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [5*DW-1:0] rx_a, tx_a, rx_b, tx_b;
   logic [4:0] drts_a, cts_a, rts_a, dcts_a, rerr_a, perr_a;
   logic [4:0] drts_b, cts_b, rts_b, dcts_b, rerr_b, perr_b;

   noc_router_mesh #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .COORD_W(2), .CUR_X(1), .CUR_Y(1), .CONN(5'b11111)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .drts(drts_a), .cts(cts_a), .tx(tx_a), .rts(rts_a),
      .dcts(dcts_a), .route_err(rerr_a), .parity_err(perr_a));

   noc_router_mesh #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .COORD_W(2), .CUR_X(1), .CUR_Y(1), .CONN(5'b01111)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .drts(drts_b), .cts(cts_b), .tx(tx_b), .rts(rts_b),
      .dcts(dcts_b), .route_err(rerr_b), .parity_err(perr_b));

   int n_chk = 0;
   int n_pass = 0;
   int rts_cnt_b = 0;
   int rerr_cnt_b = 0;
   int rerr_cnt_a = 0;
   logic [31:0] qa0[$];
   logic [31:0] qa2[$];
   logic [31:0] exp6 [6];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mk(input logic [2:0] t, input logic [3:0] dst, input logic [11:0] pl);
      logic [31:0] f;
      f = {t, 12'h000, dst, pl, 1'b0};
      f[0] = ^f[31:1];
      return f;
   endfunction

   task automatic put_a(input int p, input logic [31:0] f);
      rx_a[p*DW +: DW] = f;
      drts_a[p] = 1'b1;
   endtask

   task automatic put_b(input int p, input logic [31:0] f);
      rx_b[p*DW +: DW] = f;
      drts_b[p] = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drts_a = 5'b00000;
      drts_b = 5'b00000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Collect delivered flits and pulse counts away from the active edge
   always @(negedge clk) begin
      if (rts_a[0]) qa0.push_back(tx_a[0 +: DW]);
      if (rts_a[2]) qa2.push_back(tx_a[2*DW +: DW]);
      if (rerr_a != 5'b00000) rerr_cnt_a++;
      rts_cnt_b += $countones(rts_b);
      if (rerr_b[0]) rerr_cnt_b++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] h, b, t, b2, nh, nt, wh, wt, eh, et;
      rst = 1'b0;
      rx_a = '0; rx_b = '0;
      drts_a = 5'b00000; drts_b = 5'b00000;
      dcts_a = 5'b11111; dcts_b = 5'b11111;
      idle(2);
      check("rst_rts", {27'd0, rts_a}, 32'd0);
      check("rst_tx", {31'd0, |tx_a}, 32'd0);
      check("rst_cts", {27'd0, cts_a}, 32'd0);
      rst = 1'b1;
      step();
      check("cts_up_a", {27'd0, cts_a}, 32'h1f);
      check("cts_up_b", {27'd0, cts_b}, 32'h1f);

      // L -> E three-flit packet with header latency
      h = mk(3'b001, 4'b0110, 12'h111);
      b = mk(3'b010, 4'b0110, 12'h222);
      t = mk(3'b100, 4'b0110, 12'h333);
      put_a(0, h); step();
      put_a(0, b); step();
      put_a(0, t); step();
      check("lat_t2", {31'd0, rts_a[2]}, 32'd0);
      step();
      check("lat_t3", {31'd0, rts_a[2]}, 32'd1);
      check("lat_hdr", tx_a[2*DW +: DW], h);
      idle(5);
      check("e_len", qa2.size(), 32'd3);
      check("e_f0", qa2[0], h);
      check("e_f1", qa2[1], b);
      check("e_f2", qa2[2], t);

      // N and W contend for Local: pointer starts at 1, so N wins
      nh = mk(3'b001, 4'b0101, 12'hA01); nt = mk(3'b100, 4'b0101, 12'hA02);
      wh = mk(3'b001, 4'b0101, 12'hB01); wt = mk(3'b100, 4'b0101, 12'hB02);
      put_a(1, nh); put_a(3, wh); step();
      put_a(1, nt); put_a(3, wt); step();
      idle(10);
      check("c1_len", qa0.size(), 32'd4);
      check("c1_0", qa0[0], nh);
      check("c1_1", qa0[1], nt);
      check("c1_2", qa0[2], wh);
      check("c1_3", qa0[3], wt);

      // E takes Local alone (last grant = 2), then N/W contend again: W (3) is next in line
      qa0.delete();
      eh = mk(3'b001, 4'b0101, 12'hC01); et = mk(3'b100, 4'b0101, 12'hC02);
      put_a(2, eh); step();
      put_a(2, et); step();
      idle(6);
      put_a(1, nh); put_a(3, wh); step();
      put_a(1, nt); put_a(3, wt); step();
      idle(10);
      exp6 = '{eh, et, wh, wt, nh, nt};
      check("c2_len", qa0.size(), 32'd6);
      for (int k = 0; k < 6; k++) check($sformatf("c2_%0d", k), qa0[k], exp6[k]);

      // Router without South: header to (x=1,y=2) is dropped whole
      put_b(0, mk(3'b001, 4'b1001, 12'hD01)); step();
      put_b(0, mk(3'b010, 4'b1001, 12'hD02)); step();
      put_b(0, mk(3'b100, 4'b1001, 12'hD03)); step();
      idle(8);
      check("drop_err", rerr_cnt_b, 32'd1);
      check("drop_rts", rts_cnt_b, 32'd0);
      put_b(0, mk(3'b001, 4'b0110, 12'hD11)); step();
      put_b(0, mk(3'b100, 4'b0110, 12'hD12)); step();
      idle(6);
      check("after_drop", rts_cnt_b, 32'd2);

      // E output stalled: FIFO fills, cts drops, flits come out in order afterwards
      qa2.delete();
      dcts_a[2] = 1'b0;
      h = mk(3'b001, 4'b0110, 12'h401);
      b = mk(3'b010, 4'b0110, 12'h402);
      b2 = mk(3'b010, 4'b0110, 12'h403);
      t = mk(3'b100, 4'b0110, 12'h404);
      put_a(0, h); step();
      put_a(0, b); step();
      put_a(0, b2); step();
      check("cts_not_full", {31'd0, cts_a[0]}, 32'd1);
      put_a(0, t); step();
      check("cts_full", {31'd0, cts_a[0]}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_rts", {31'd0, rts_a[2]}, 32'd0);
      end
      dcts_a[2] = 1'b1;
      idle(8);
      check("st_len", qa2.size(), 32'd4);
      check("st_0", qa2[0], h);
      check("st_1", qa2[1], b);
      check("st_2", qa2[2], b2);
      check("st_3", qa2[3], t);
      check("cts_drained", {31'd0, cts_a[0]}, 32'd1);

      // Reset mid-packet, then a clean packet
      put_a(0, mk(3'b001, 4'b0110, 12'h501)); step();
      put_a(0, mk(3'b010, 4'b0110, 12'h502)); step();
      idle(2);
      check("pre_rst_rts", {31'd0, rts_a[2]}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_rts", {27'd0, rts_a}, 32'd0);
      step();
      rst = 1'b1;
      step();
      qa2.delete();
      h = mk(3'b001, 4'b0110, 12'h601);
      t = mk(3'b100, 4'b0110, 12'h602);
      put_a(0, h); step();
      put_a(0, t); step();
      idle(6);
      check("post_len", qa2.size(), 32'd2);
      check("post_0", qa2[0], h);
      check("post_1", qa2[1], t);

      // Parity: corrupted bit 0 flags the input and is regenerated on output
      qa0.delete();
`ifdef NOC_PARITY_EN
      h = mk(3'b001, 4'b0101, 12'h5A5);
      t = mk(3'b100, 4'b0101, 12'h5A6);
      put_a(1, h ^ 32'h0000_0001); step();
      put_a(1, t); step();
      idle(6);
      check("par_flag", {31'd0, perr_a[1]}, 32'd1);
      check("par_fixed", qa0[0], h);
      check("par_others", {28'd0, perr_a[4:2], perr_a[0]}, 32'd0);
      idle(5);
      check("par_sticky", {31'd0, perr_a[1]}, 32'd1);
`else
      check("par_off_a", {27'd0, perr_a}, 32'd0);
      check("par_off_b", {27'd0, perr_b}, 32'd0);
`endif
      check("no_err_a", rerr_cnt_a, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
